// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 enabled mux, with a one-cycle break-before-make gap between owners.
// Optional forced release after MAX_HOLD grant cycles is built only when ARB_TIMEOUT_EN is defined.
module mux_4_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
);

  // Handshake: req[i] is a level request; gnt[i] is high for every cycle source i
  // owns the mux. The owner releases by dropping req[i]; en stays low for exactly
  // one GAP cycle before any new owner is connected.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic       any_req;
  logic       grant_now;
  logic       hold_expired;

  if (!((2 ** CNT_W) > MAX_HOLD)) begin : g_cnt_w_check
    $error("CNT_W too small for MAX_HOLD");
  end

  // Scan ptr+1, ptr+2, ptr+3, ptr (wrapping); the closest set bit wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    any_req   = |req;
    win       = pick(req, ptr);
    grant_now = any_req && ((state == IDLE) || (state == GAP));
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_comb hold_expired = (cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst || grant_now) begin
      cnt <= '0;
    end else if ((state == GRANT) && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  always_comb hold_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      ptr   <= 2'd3;
    end else if (grant_now) begin
      state <= GRANT;
      gnt   <= 4'b0001 << win;
      sel   <= win;
      en    <= 1'b1;
      busy  <= 1'b1;
      ptr   <= win;
    end else begin
      case (state)
        GRANT: begin
          if (!req[sel] || hold_expired) begin
            state <= GAP;
            gnt   <= '0;
            en    <= 1'b0;
          end
        end
        GAP: begin
          // No request seen during the gap; sel keeps the last owner.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
